led_indicator_bank: RTL and testbench

LED_INDICATOR_BANK -- requirements
Module: led_indicator_bank

---
 rtl/led_indicator_bank.sv | 90 +++++++++
 tb/tb_led_indicator_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_indicator_bank.sv
// Bank of LED drivers: per-channel mode (off/on/blink/activity) with a shared
// tick prescaler, a global blink phase and per-channel activity pulse stretching.
module led_indicator_bank #(
  parameter int          CHANNELS      = 8,
  parameter int          TICK_DIV      = 6000000,
  parameter int          STRETCH_TICKS = 2,
  parameter logic [1:0]  DEF_MODE      = 2'b10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CHANNELS-1:0] events,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STRETCH_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(STRETCH_TICKS);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_ACT   = 2'b11;

  logic [PW-1:0] presc_reg;
  logic          phase_reg;
  logic          tick_int;
  logic          cfg_ok;

  assign tick_int = (presc_reg == PRESC_LAST);
  assign cfg_ok   = cfg_we && (32'(cfg_ch) < CHANNELS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      phase_reg <= 1'b0;
      tick      <= 1'b0;
    end else begin
      presc_reg <= tick_int ? '0 : presc_reg + PW'(1);
      phase_reg <= phase_reg ^ tick_int;
      tick      <= tick_int;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [1:0]    mode_reg, mode_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          led_reg;

    // The event rule follows the mode being written this cycle, not the old one.
    always_comb begin
      mode_next = mode_reg;
      if (cfg_ok && (cfg_ch == 5'(gi)))
        mode_next = cfg_mode;
      cnt_next = '0;
      if (mode_next == MODE_ACT) begin
        if (events[gi])
          cnt_next = CNT_LOAD;
        else if (tick_int && (cnt_reg != '0))
          cnt_next = cnt_reg - CW'(1);
        else
          cnt_next = cnt_reg;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_reg <= DEF_MODE;
        cnt_reg  <= '0;
        led_reg  <= 1'b0;
      end else begin
        mode_reg <= mode_next;
        cnt_reg  <= cnt_next;
        case (mode_reg)
          MODE_OFF:   led_reg <= 1'b0;
          MODE_ON:    led_reg <= 1'b1;
          MODE_BLINK: led_reg <= phase_reg;
          default:    led_reg <= (cnt_reg != '0);
        endcase
      end
    end

    assign led[gi] = led_reg;
  end

endmodule

// File: tb/tb_led_indicator_bank.sv
// Directed bench for led_indicator_bank: a behavioural model pushes the expected
// {tick, led} per cycle to a queue, popped and compared after each clock edge.
module tb_led_indicator_bank;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CH-1:0] events = '0;
  logic [CH-1:0] led;
  logic          tick;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_presc;
  bit         m_phase;
  logic [1:0] m_mode [CH];
  int         m_cnt  [CH];
  logic [CH:0] sb_q [$];

  always #5 clk = ~clk;

  led_indicator_bank #(
    .CHANNELS(CH), .TICK_DIV(TD), .STRETCH_TICKS(ST), .DEF_MODE(2'b10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .events(events), .led(led), .tick(tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_phase = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 2'b10;
      m_cnt[i]  = 0;
    end
  endtask

  // One clock edge: predict outputs from the pre-edge model state, advance the model.
  task automatic cycle();
    bit          t;
    logic [CH-1:0] el;
    logic [CH:0]   got, exp;
    t = (m_presc == TD - 1);
    for (int i = 0; i < CH; i++) begin
      case (m_mode[i])
        2'b00:   el[i] = 1'b0;
        2'b01:   el[i] = 1'b1;
        2'b10:   el[i] = m_phase;
        default: el[i] = (m_cnt[i] != 0);
      endcase
    end
    sb_q.push_back({t, el});
    if (cfg_we && int'(cfg_ch) < CH)
      m_mode[int'(cfg_ch)] = cfg_mode;
    for (int i = 0; i < CH; i++) begin
      if (m_mode[i] == 2'b11) begin
        if (events[i]) m_cnt[i] = ST;
        else if (t && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end else begin
        m_cnt[i] = 0;
      end
    end
    if (t) begin
      m_phase = !m_phase;
      m_presc = 0;
    end else begin
      m_presc = m_presc + 1;
    end
    @(posedge clk);
    @(negedge clk);
    exp = sb_q.pop_front();
    got = {tick, led};
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL scoreboard: observed %b expected %b", got, exp);
    end
    cfg_we = 1'b0;
    events = '0;
  endtask

  task automatic write(input int ch, input logic [1:0] mode);
    cfg_we   = 1'b1;
    cfg_ch   = 5'(ch);
    cfg_mode = mode;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    model_reset();
    #12;
    check("reset_led", 32'(led), 32'(0));
    check("reset_tick", 32'(tick), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: all channels blink, tick every 4 cycles
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (k == 3) check("no_early_tick", 32'(tick), 32'(0));
      if (k == 4) begin
        check("first_tick", 32'(tick), 32'(1));
        check("blink_still_off", 32'(led), 32'(0));
      end
      if (k == 5) begin
        check("blink_on", 32'(led), 32'hF);
        check("tick_one_cycle", 32'(tick), 32'(0));
      end
      if (k == 8) check("second_tick", 32'(tick), 32'(1));
      if (k == 9) check("blink_off", 32'(led), 32'(0));
    end

    // Activity stretch on ch1
    write(1, 2'b11);
    cycle();
    events = 4'b0010;
    cycle();
    check("act_lat_edge_k", 32'(led[1]), 32'(0));
    cycle();
    check("act_lat_edge_k1", 32'(led[1]), 32'(1));
    hi = 1;
    for (int j = 0; j < 20; j++) begin
      cycle();
      if (led[1]) hi++;
      else break;
    end
    check("act_stretch_len", 32'(hi), 32'(6));

    // Retrigger: event on a tick, 3 cycles later, and on the next tick
    for (int j = 0; j < TD && m_presc != TD - 1; j++) cycle();
    events = 4'b0010;
    cycle();
    for (int j = 1; j <= 13; j++) begin
      if (j == 3 || j == 4) events = 4'b0010;
      cycle();
      check("act_nogap", 32'(led[1]), 32'(j < 13));
    end

    // Out-of-range channel write is ignored; ON then OFF gives a single-cycle pulse
    write(5, 2'b01);
    cycle();
    cycle();
    check("bad_ch_ignored", 32'(led[1]), 32'(0));
    write(2, 2'b01);
    cycle();
    write(2, 2'b00);
    cycle();
    check("on_pulse_hi", 32'(led[2]), 32'(1));
    cycle();
    check("on_pulse_lo", 32'(led[2]), 32'(0));
    cycle();
    check("off_stays_lo", 32'(led[2]), 32'(0));

    // Write to ACTIVITY with a coincident event applies the new mode's rule
    write(2, 2'b11);
    events = 4'b0100;
    cycle();
    cycle();
    check("write_evt_same", 32'(led[2]), 32'(1));

    // Reset mid-stretch and mid-write
    write(0, 2'b11);
    cycle();
    events = 4'b0001;
    cycle();
    cycle();
    check("ch0_active", 32'(led[0]), 32'(1));
    #1;
    rst_n    = 1'b0;
    cfg_we   = 1'b1;
    cfg_ch   = 5'd3;
    cfg_mode = 2'b01;
    #1;
    check("async_led", 32'(led), 32'(0));
    check("async_tick", 32'(tick), 32'(0));
    @(negedge clk);
    cfg_we = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    for (int j = 1; j <= 4; j++) begin
      cycle();
      check("post_rst_led", 32'(led), 32'(0));
      check("post_rst_tick", 32'(tick), 32'(j == 4));
    end
    cycle();
    check("post_rst_blink", 32'(led), 32'hF);

    // Event while OFF is not remembered by a later switch to ACTIVITY
    write(3, 2'b00);
    cycle();
    events = 4'b1000;
    cycle();
    write(3, 2'b11);
    cycle();
    for (int j = 0; j < 4; j++) begin
      cycle();
      check("off_event_ignored", 32'(led[3]), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
